instr_prefetch: RTL and testbench
=================================

# instr_prefetch

Instruction prefetch stage sitting directly upstream of the single-cycle core's decode/execute path. Reads the byte-wide, big-endian instruction memory one byte per cycle, assembles 32-bit instruction words with their PC, and buffers them in a small FIFO. The core consumes words through a valid/ready handshake. It redirects the fetch stream (with flush) on taken branch/jump.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `ADDR_W`, 5: instruction-memory byte address width (32-byte memory).
- `RESET_PC`, 32'h0: first fetch address after reset; bits [1:0] must be 0.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_addr`  out  ADDR_W  byte address to instruction memory.
- `imem_rdata`  in  8  byte at `imem_addr`; combinational (same-cycle) read.
- `redirect`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- `inst_valid`  out  1  FIFO head holds a word.
- `inst`  out  32  head instruction word.
- `inst_pc`  out  32  PC of head word.
- `inst_ready`  in  1  core accepts head this cycle.

## Operation
- Registers: `fetch_pc` (32b), `byte_idx` (2b), `asm_hi` (24b, bytes 0–2), FIFO of {pc, word}, `count` ($clog2(DEPTH)+1 bits).
- `imem_addr = (fetch_pc[ADDR_W-1:0] + byte_idx)` mod 2^ADDR_W. Addresses wrap within the memory; `fetch_pc` itself wraps mod 2^32.
- Byte order: byte_idx 0 → inst[31:24], 1 → [23:16], 2 → [15:8], 3 → [7:0].
- FSM states:
  - FILL: byte_idx 0..2. Capture `imem_rdata` into `asm_hi`, then byte_idx+1. At byte_idx=2, go to LAST.
  - LAST: byte_idx=3. A push happens if `space = (count<DEPTH) || pop`. On push, write {fetch_pc, asm_hi, imem_rdata}, set `fetch_pc += 4` and byte_idx=0, and go to FILL. If there is no space, stay in LAST; the address holds and the byte is re-read.
- `pop = inst_valid && inst_ready`. Advance the head.
- `inst_valid = (count != 0)`. When empty, `inst`/`inst_pc` read 0.
- Redirect (highest priority):
  - Clear the FIFO (count=0) and discard the partial word.
  - Set `fetch_pc = {redirect_pc[31:2],2'b00}`, byte_idx=0, state FILL.
  - Any push or pop in the same cycle is ignored. `inst_ready` in that cycle does not count as consumption.
- Simultaneous push and pop when full: both take effect and count is unchanged.

## Timing
- Reset values: `inst_valid`=0, `inst`=0, `inst_pc`=0, `imem_addr`=RESET_PC[ADDR_W-1:0], `fetch_pc`=RESET_PC, byte_idx=0, state FILL, count=0.
- Throughput: one word per 4 cycles when not full.
- Latency:
  - First word: the fetch uses 4 rising edges after reset release; `inst_valid` rises after the 4th edge.
  - After redirect: sampled at edge E, `inst_valid` is 0 from E; the new word is valid after edge E+4.
- Handshake: `inst`/`inst_pc` stay stable while `inst_valid && !inst_ready`. They change only on pop or redirect.
- Reset asserted mid-word or mid-handshake: all state returns to reset values immediately (asynchronous).

## Configuration
- `IPF_STATS_EN` defined:
  - Adds outputs `stat_words` (out, 16) and `stat_flushes` (out, 16), both reset to 0.
  - `stat_words` increments on every push; `stat_flushes` increments on every `redirect`.
  - Both saturate at 16'hFFFF.
- Undefined: the ports and counters are absent; the rest of the behaviour is identical.

## Structure
- Package `ipf_pkg`:
  - FSM state enum {FILL, LAST}.
  - Entry struct {pc[31:0], word[31:0]}.
  - Byte-lane constants.
- Sub-module `ipf_fifo`:
  - Parameterised synchronous FIFO of `ipf_pkg` entries.
  - Ports: push/pop/flush, full/empty, count.
  - Async active-low reset.

## Test plan
- Reset release, imem bytes 0..7 = 20 01 00 05 8C 22 00 00, `inst_ready`=1 → after 4 edges `inst`=32'h20010005, `inst_pc`=0; 4 edges later `inst`=32'h8C220000, `inst_pc`=4.
- `inst_ready`=0 for 30 cycles → exactly DEPTH=4 words buffered, then FSM holds in LAST; `imem_addr` stays at 16+3=19; `inst` stays at PC 0 word.
- Redirect to 32'h0000_0012 while 2 words are queued and mid-word → `inst_valid` 0 next cycle; the next word has `inst_pc`=32'h10 (low bits forced), assembled from bytes 16..19.
- `fetch_pc`=28 → word assembled from bytes 28..31; the next fetch `imem_addr` wraps to 0 while `inst_pc`=32.
- FIFO full, pop and LAST push in the same cycle → count stays 4 and no word is lost or duplicated.
- With `IPF_STATS_EN`: 5 words pushed, 2 redirects → `stat_words`=5, `stat_flushes`=2; reset mid-run → both return to 0.

Source files
------------

// File: rtl/ipf_pkg.sv
// ----------------------------------------------------------------------------
// ipf_pkg
// Shared types and constants for the instruction prefetch stage.
//   ipf_state_e : byte-assembly FSM state (FILL bytes 0..2, LAST byte 3)
//   ipf_entry_t : FIFO entry, {pc, word}
//   LANE_*      : byte_idx value for each byte lane of a big-endian word
// ----------------------------------------------------------------------------
package ipf_pkg;

  typedef enum logic {
    FILL = 1'b0,
    LAST = 1'b1
  } ipf_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } ipf_entry_t;

  // byte_idx for each lane; lane 0 lands in word[31:24]
  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;

  localparam logic [31:0] WORD_BYTES = 32'd4;

endpackage

// File: rtl/ipf_fifo.sv
// ----------------------------------------------------------------------------
// ipf_fifo
// Synchronous FIFO of ipf_entry_t with flush. A push while full is accepted
// when a pop happens in the same cycle. Flush empties the FIFO and overrides
// any push/pop in that cycle.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, pop_i   : enqueue wdata_i / dequeue head
//   flush_i         : discard all entries
//   wdata_i         : entry to enqueue
//   rdata_o         : head entry (contents undefined when empty)
//   full_o, empty_o : status
//   count_o         : number of stored entries
// ----------------------------------------------------------------------------
module ipf_fifo
  import ipf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  ipf_entry_t               wdata_i,
  output ipf_entry_t               rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ipf_entry_t         mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push;
  logic               do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_push = push_i && (!full_o || pop_i) && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; validity is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/instr_prefetch.sv
// ----------------------------------------------------------------------------
// instr_prefetch
// Fetches one byte per cycle from a byte-wide big-endian instruction memory,
// assembles 32-bit words tagged with their PC and queues them for the core.
// A redirect flushes the queue and the partial word and restarts fetch.
// Optional build macro: IPF_STATS_EN adds saturating push/flush counters.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_addr         : byte address to instruction memory
//   imem_rdata        : byte at imem_addr, same-cycle read
//   redirect          : flush and restart at redirect_pc
//   redirect_pc       : new fetch PC (bits [1:0] forced to 0)
//   inst_valid        : head word is valid
//   inst, inst_pc     : head word and its PC (0 when empty)
//   inst_ready        : core takes the head word this cycle
//   stat_words        : (IPF_STATS_EN) words pushed, saturating
//   stat_flushes      : (IPF_STATS_EN) redirects seen, saturating
// ----------------------------------------------------------------------------
module instr_prefetch
  import ipf_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_rdata,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic              inst_valid,
  output logic [31:0]       inst,
  output logic [31:0]       inst_pc,
`ifdef IPF_STATS_EN
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_flushes,
`endif
  input  logic              inst_ready
);

  ipf_state_e               state_q, state_d;
  logic [31:0]              fetch_pc_q, fetch_pc_d;
  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [23:0]              asm_hi_q, asm_hi_d;
  logic                     push;
  logic                     pop_req;
  logic                     space;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(DEPTH):0]   fifo_count;
  ipf_entry_t               fifo_wdata;
  ipf_entry_t               fifo_head;
  logic                     unused_rpc_lo;

  assign unused_rpc_lo = ^redirect_pc[1:0];

  assign imem_addr = fetch_pc_q[ADDR_W-1:0] + ADDR_W'(byte_idx_q);

  // The FIFO ignores push/pop while flushing, so a redirect cycle never
  // counts as consumption.
  assign pop_req = inst_valid && inst_ready;
  assign space   = !fifo_full || pop_req;

  assign fifo_wdata.pc   = fetch_pc_q;
  assign fifo_wdata.word = {asm_hi_q, imem_rdata};

  assign inst_valid = (fifo_count != '0);
  assign inst       = fifo_empty ? 32'h0 : fifo_head.word;
  assign inst_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_idx_d = byte_idx_q;
    asm_hi_d   = asm_hi_q;
    push       = 1'b0;
    if (redirect) begin
      state_d    = FILL;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      byte_idx_d = LANE_B0;
    end else begin
      unique case (state_q)
        FILL: begin
          unique case (byte_idx_q)
            LANE_B0: asm_hi_d[23:16] = imem_rdata;
            LANE_B1: asm_hi_d[15:8]  = imem_rdata;
            default: asm_hi_d[7:0]   = imem_rdata;
          endcase
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == LANE_B2) state_d = LAST;
        end
        LAST: begin
          // Without space the address holds and the last byte is re-read
          if (space) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + WORD_BYTES;
            byte_idx_d = LANE_B0;
            state_d    = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fetch_pc_q <= RESET_PC;
      byte_idx_q <= LANE_B0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    asm_hi_q <= asm_hi_d;
  end

  ipf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop_req),
    .flush_i (redirect),
    .wdata_i (fifo_wdata),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

`ifdef IPF_STATS_EN
  logic [15:0] stat_words_q, stat_words_d;
  logic [15:0] stat_flushes_q, stat_flushes_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    stat_words_d   = push     ? sat_inc16(stat_words_q)   : stat_words_q;
    stat_flushes_d = redirect ? sat_inc16(stat_flushes_q) : stat_flushes_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_words_q   <= 16'h0;
      stat_flushes_q <= 16'h0;
    end else begin
      stat_words_q   <= stat_words_d;
      stat_flushes_q <= stat_flushes_d;
    end
  end

  assign stat_words   = stat_words_q;
  assign stat_flushes = stat_flushes_q;
`endif

endmodule

// File: tb/tb_instr_prefetch.sv
module tb_instr_prefetch;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [7:0]        imem_rdata;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              inst_ready;
`ifdef IPF_STATS_EN
  logic [15:0]       stat_words;
  logic [15:0]       stat_flushes;
`endif

  logic [7:0] mem [32];
  assign imem_rdata = mem[imem_addr];

  instr_prefetch #(
    .DEPTH    (DEPTH),
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .inst_valid   (inst_valid),
    .inst         (inst),
    .inst_pc      (inst_pc),
`ifdef IPF_STATS_EN
    .stat_words   (stat_words),
    .stat_flushes (stat_flushes),
`endif
    .inst_ready   (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h @%0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Queue of {pc, word}; a word enters after four fetch cycles and its value
  // is read straight from the memory image.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;
  int          m_prog;     // bytes of the current word already fetched
  int          m_words;
  int          m_flushes;

  function automatic logic [31:0] mword(input logic [31:0] pc);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[31-8*k -: 8] = mem[(int'(pc[4:0]) + k) % 32];
    return r;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_prog = 0; m_words = 0; m_flushes = 0;
  endtask

  task automatic model_step(input logic rdy, input logic rd, input logic [31:0] rpc);
    bit pop;
    ent_t e;
    if (rd) begin
      mq.delete();
      m_pc = rpc & 32'hFFFF_FFFC;
      m_prog = 0;
      if (m_flushes < 16'hFFFF) m_flushes++;
    end else begin
      pop = (mq.size() != 0) && rdy;
      if (m_prog < 3) begin
        m_prog++;
        if (pop) void'(mq.pop_front());
      end else begin
        if (mq.size() < DEPTH || pop) begin
          if (pop) void'(mq.pop_front());
          e.pc = m_pc; e.w = mword(m_pc);
          mq.push_back(e);
          m_pc = m_pc + 32'd4;
          m_prog = 0;
          if (m_words < 16'hFFFF) m_words++;
        end else if (pop) begin
          void'(mq.pop_front());
        end
      end
    end
  endtask

  task automatic compare();
    chk("valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
    chk("inst",  inst,    (mq.size() != 0) ? mq[0].w  : 32'h0);
    chk("pc",    inst_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("addr",  {27'b0, imem_addr}, {27'b0, 5'(m_pc[4:0] + 5'(m_prog))});
`ifdef IPF_STATS_EN
    chk("stat_words",   {16'b0, stat_words},   m_words);
    chk("stat_flushes", {16'b0, stat_flushes}, m_flushes);
`endif
  endtask

  // Inputs change on the falling edge, outputs are checked on the next one
  task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
    inst_ready = rdy; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    model_step(rdy, rd, rpc);
    @(negedge clk);
    compare();
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge
  task automatic async_reset();
    #2;
    rst_n = 1'b0;
    inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_w;

  initial begin
    rst_n = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h20; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h05;
    mem[4] = 8'h8C; mem[5] = 8'h22; mem[6] = 8'h00; mem[7] = 8'h00;
    model_reset();
    #2;
    compare();
    chk("rst_addr", {27'b0, imem_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // first two words, streaming
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    chk("w0_inst", inst, 32'h20010005);
    chk("w0_pc", inst_pc, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    chk("w1_inst", inst, 32'h8C220000);
    chk("w1_pc", inst_pc, 32'h4);

    // back-pressure: FIFO fills and fetch parks on byte 3 of PC 16
    async_reset();
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 32'h0);
    chk("hold_addr", {27'b0, imem_addr}, 32'd19);
    chk("hold_pc", inst_pc, 32'h0);
    chk("hold_inst", inst, 32'h20010005);

    // redirect with two words queued and a third in progress
    async_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);
    chk("pre_redir_valid", {31'b0, inst_valid}, 32'h1);
    step(1'b1, 1'b1, 32'h0000_0012);
    chk("redir_valid", {31'b0, inst_valid}, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    exp_w = {mem[16], mem[17], mem[18], mem[19]};
    chk("redir_pc", inst_pc, 32'h10);
    chk("redir_inst", inst, exp_w);

    // memory address wrap
    step(1'b1, 1'b1, 32'd28);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    exp_w = {mem[28], mem[29], mem[30], mem[31]};
    chk("wrap_pc", inst_pc, 32'd28);
    chk("wrap_inst", inst, exp_w);
    chk("wrap_addr", {27'b0, imem_addr}, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);
    chk("wrap_pc2", inst_pc, 32'd32);
    chk("wrap_inst2", inst, 32'h20010005);

    // full FIFO: pop and push on the same edge, then drain in order
    async_reset();
    for (int i = 0; i < 19; i++) step(1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    chk("fullpp_pc", inst_pc, 32'h4);
    step(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 32'h0);
      chk("drain_pc", inst_pc, 32'h8 + 32'(4 * i));
    end

`ifdef IPF_STATS_EN
    async_reset();
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h0);
    step(1'b1, 1'b1, 32'h8);
    chk("stat_words5", {16'b0, stat_words}, 32'd5);
    chk("stat_flush2", {16'b0, stat_flushes}, 32'd2);
    async_reset();
    chk("stat_words_rst", {16'b0, stat_words}, 32'd0);
    chk("stat_flush_rst", {16'b0, stat_flushes}, 32'd0);
`endif

    // randomized traffic with occasional redirects and async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) async_reset();
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 29) == 0), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
